// File: rtl/irq_dispatch_pkg.sv
// Shared types and default sizing for the interrupt dispatch controller.
package irq_dispatch_pkg;

    localparam int DEF_NUM_LINES   = 32;
    localparam int DEF_ACK_TIMEOUT = 256;
    localparam int DEF_CLR_SETTLE  = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        REQ,
        CLEAR,
        SETTLE
    } state_t;

endpackage

// File: rtl/irq_dispatch_ctrl_if.sv
// Signal bundle between the service unit/core side (master) and the dispatcher (slave).
interface irq_dispatch_ctrl_if
    import irq_dispatch_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES
);
    localparam int ID_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    logic [NUM_LINES-1:0] pending_i;
    logic                 core_sleeping_i;
    logic                 irq_ack_i;
    logic                 timeout_clr_i;
    logic                 irq_req_o;
    logic [ID_W-1:0]      irq_id_o;
    logic [NUM_LINES-1:0] clear_o;
    logic                 wake_o;
    logic                 timeout_o;

    modport master (
        output pending_i, core_sleeping_i, irq_ack_i, timeout_clr_i,
        input  irq_req_o, irq_id_o, clear_o, wake_o, timeout_o
    );

    modport slave (
        input  pending_i, core_sleeping_i, irq_ack_i, timeout_clr_i,
        output irq_req_o, irq_id_o, clear_o, wake_o, timeout_o
    );

endinterface

// File: rtl/irq_dispatch_ctrl_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of vec wins.
module prio_enc #(
    parameter int N     = 32,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    assign valid = |vec;

    // NOTE: blocking assignments in combinational logic; scanning downward lets the lowest index overwrite last.
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/irq_dispatch_ctrl.sv
// Dispatches the highest-priority pending line to the core, handles wake, ack timeout and clear.
module irq_dispatch_ctrl
    import irq_dispatch_pkg::*;
#(
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CLR_SETTLE  = DEF_CLR_SETTLE
) (
    input  logic                HCLK,
    input  logic                HRESET,
    irq_dispatch_ctrl_if.slave  bus
);

    localparam int ID_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CNT_MAX = (ACK_TIMEOUT > CLR_SETTLE) ? ACK_TIMEOUT : CLR_SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((CLR_SETTLE > 0) ? CLR_SETTLE - 1 : 0);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ID_W-1:0]      id_q;
    logic                 irq_req_q;
    logic [NUM_LINES-1:0] clear_q;
    logic                 wake_q;
    logic                 timeout_q;

    logic                 win_valid;
    logic [ID_W-1:0]      win_idx;

    prio_enc #(
        .N     (NUM_LINES),
        .IDX_W (ID_W)
    ) u_prio_enc (
        .vec   (bus.pending_i),
        .valid (win_valid),
        .index (win_idx)
    );

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // NOTE: reset is synchronous, so it lives inside the clocked block and all state uses <=.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            id_q      <= '0;
            irq_req_q <= 1'b0;
            clear_q   <= '0;
            wake_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            clear_q <= '0;
            if (bus.timeout_clr_i) timeout_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        if (bus.core_sleeping_i) begin
                            state_q <= WAKE;
                            wake_q  <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            id_q      <= win_idx;
                            cnt_q     <= '0;
                            irq_req_q <= 1'b1;
                        end
                    end
                end

                WAKE: begin
                    if (!bus.core_sleeping_i || !win_valid) begin
                        state_q <= IDLE;
                        wake_q  <= 1'b0;
                    end
                end

                REQ: begin
                    // Ack outranks both withdrawal and timeout in the same cycle.
                    if (bus.irq_ack_i) begin
                        state_q   <= CLEAR;
                        irq_req_q <= 1'b0;
                        clear_q   <= NUM_LINES'(1) << id_q;
                    end else if (!bus.pending_i[id_q]) begin
                        state_q   <= IDLE;
                        irq_req_q <= 1'b0;
                    end else if (cnt_q == ACK_LAST) begin
                        state_q   <= IDLE;
                        irq_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                CLEAR: begin
                    state_q <= SETTLE;
                    cnt_q   <= '0;
                end

                SETTLE: begin
                    if (cnt_q >= SETTLE_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                    wake_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_req_o = irq_req_q;
    assign bus.irq_id_o  = id_q;
    assign bus.clear_o   = clear_q;
    assign bus.wake_o    = wake_q;
    assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Directed bench for irq_dispatch_ctrl: dispatch, wake, timeout, withdrawal and reset cases.
module tb_irq_dispatch_ctrl;
    import irq_dispatch_pkg::*;

    logic HCLK = 1'b0;
    logic HRESET;
    int   total = 0;
    int   bad   = 0;

    irq_dispatch_ctrl_if #(.NUM_LINES(32)) bus ();

    irq_dispatch_ctrl #(
        .NUM_LINES   (32),
        .ACK_TIMEOUT (256),
        .CLR_SETTLE  (2)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        HRESET              = 1'b1;
        bus.pending_i       = '0;
        bus.core_sleeping_i = 1'b0;
        bus.irq_ack_i       = 1'b0;
        bus.timeout_clr_i   = 1'b0;
        tick(2);
        check("rst_req",     {31'd0, bus.irq_req_o}, 32'd0);
        check("rst_id",      {27'd0, bus.irq_id_o},  32'd0);
        check("rst_clear",   bus.clear_o,            32'd0);
        check("rst_wake",    {31'd0, bus.wake_o},    32'd0);
        check("rst_timeout", {31'd0, bus.timeout_o}, 32'd0);
        HRESET = 1'b0;

        // Ack outside REQ is ignored.
        bus.irq_ack_i = 1'b1;
        tick();
        check("idle_ack_clear", bus.clear_o,            32'd0);
        check("idle_ack_req",   {31'd0, bus.irq_req_o}, 32'd0);
        bus.irq_ack_i = 1'b0;

        // Basic dispatch: lines 2 and 4 pending, 2 wins.
        bus.pending_i = 32'h0000_0014;
        tick();
        check("disp_req",   {31'd0, bus.irq_req_o}, 32'd1);
        check("disp_id",    {27'd0, bus.irq_id_o},  32'd2);
        tick(2);
        check("disp_id_stable", {27'd0, bus.irq_id_o}, 32'd2);
        check("disp_no_clear",  bus.clear_o,           32'd0);
        bus.irq_ack_i = 1'b1;
        tick();
        check("disp_clear", bus.clear_o,            32'h0000_0004);
        check("disp_req_lo",{31'd0, bus.irq_req_o}, 32'd0);
        bus.irq_ack_i = 1'b0;
        bus.pending_i = 32'h0000_0010;
        tick();
        check("settle1_clear", bus.clear_o,            32'd0);
        check("settle1_req",   {31'd0, bus.irq_req_o}, 32'd0);
        tick();
        check("settle2_req",   {31'd0, bus.irq_req_o}, 32'd0);
        tick();
        check("idle_req",      {31'd0, bus.irq_req_o}, 32'd0);
        tick();
        check("disp2_req",     {31'd0, bus.irq_req_o}, 32'd1);
        check("disp2_id",      {27'd0, bus.irq_id_o},  32'd4);
        bus.irq_ack_i = 1'b1;
        tick();
        check("disp2_clear",   bus.clear_o,            32'h0000_0010);
        bus.irq_ack_i = 1'b0;
        bus.pending_i = '0;
        tick(4);

        // Wake path: sleeping core, line 31.
        bus.core_sleeping_i = 1'b1;
        bus.pending_i       = 32'h8000_0000;
        tick();
        check("wake_on",     {31'd0, bus.wake_o},    32'd1);
        check("wake_no_req", {31'd0, bus.irq_req_o}, 32'd0);
        tick();
        check("wake_hold",   {31'd0, bus.wake_o},    32'd1);
        bus.core_sleeping_i = 1'b0;
        tick();
        check("wake_off",    {31'd0, bus.wake_o},    32'd0);
        check("wake_idle_req", {31'd0, bus.irq_req_o}, 32'd0);
        tick();
        check("wake_req",    {31'd0, bus.irq_req_o}, 32'd1);
        check("wake_id",     {27'd0, bus.irq_id_o},  32'd31);
        bus.pending_i = '0;
        tick();
        check("wake_wd_req", {31'd0, bus.irq_req_o}, 32'd0);
        // Wake abandoned when pending goes away.
        bus.core_sleeping_i = 1'b1;
        bus.pending_i       = 32'h0000_0001;
        tick();
        check("wake2_on",  {31'd0, bus.wake_o}, 32'd1);
        bus.pending_i = '0;
        tick();
        check("wake2_off", {31'd0, bus.wake_o}, 32'd0);
        bus.core_sleeping_i = 1'b0;
        tick();

        // Timeout: 256 REQ cycles without ack.
        bus.pending_i = 32'h0000_0001;
        tick();
        check("to_req_first", {31'd0, bus.irq_req_o}, 32'd1);
        tick(255);
        check("to_req_last",  {31'd0, bus.irq_req_o}, 32'd1);
        check("to_flag_pre",  {31'd0, bus.timeout_o}, 32'd0);
        tick();
        check("to_req_drop",  {31'd0, bus.irq_req_o}, 32'd0);
        check("to_flag_set",  {31'd0, bus.timeout_o}, 32'd1);
        check("to_no_clear",  bus.clear_o,            32'd0);
        bus.pending_i = '0;
        tick();
        check("to_sticky",    {31'd0, bus.timeout_o}, 32'd1);
        bus.timeout_clr_i = 1'b1;
        tick();
        check("to_cleared",   {31'd0, bus.timeout_o}, 32'd0);
        bus.timeout_clr_i = 1'b0;

        // Ack in the final REQ cycle beats the timeout.
        bus.pending_i = 32'h0000_0001;
        tick(256);
        bus.irq_ack_i = 1'b1;
        tick();
        check("to_ack_clear", bus.clear_o,            32'h0000_0001);
        check("to_ack_flag",  {31'd0, bus.timeout_o}, 32'd0);
        bus.irq_ack_i = 1'b0;
        bus.pending_i = '0;
        tick(4);

        // Timeout set beats a coincident clear.
        bus.pending_i = 32'h0000_0001;
        tick(256);
        bus.timeout_clr_i = 1'b1;
        tick();
        check("to_set_wins",  {31'd0, bus.timeout_o}, 32'd1);
        bus.timeout_clr_i = 1'b0;
        bus.pending_i     = '0;
        tick();

        // Withdrawal of line 5 without ack.
        bus.pending_i = 32'h0000_0020;
        tick();
        check("wd_req", {31'd0, bus.irq_req_o}, 32'd1);
        check("wd_id",  {27'd0, bus.irq_id_o},  32'd5);
        bus.pending_i = '0;
        tick();
        check("wd_req_drop", {31'd0, bus.irq_req_o}, 32'd0);
        check("wd_clear0",   bus.clear_o,            32'd0);
        tick();
        check("wd_clear1",   bus.clear_o,            32'd0);
        // Coincident ack and withdrawal: ack wins.
        bus.pending_i = 32'h0000_0020;
        tick();
        bus.pending_i = '0;
        bus.irq_ack_i = 1'b1;
        tick();
        check("wd_ack_clear", bus.clear_o, 32'h0000_0020);
        bus.irq_ack_i = 1'b0;
        tick(4);

        // Reset mid-REQ aborts with no clear pulse and clears the sticky flag.
        bus.pending_i = 32'h0000_0008;
        tick();
        check("rr_id", {27'd0, bus.irq_id_o}, 32'd3);
        HRESET        = 1'b1;
        bus.irq_ack_i = 1'b1;
        tick();
        check("rr_req",     {31'd0, bus.irq_req_o}, 32'd0);
        check("rr_id0",     {27'd0, bus.irq_id_o},  32'd0);
        check("rr_clear",   bus.clear_o,            32'd0);
        check("rr_timeout", {31'd0, bus.timeout_o}, 32'd0);
        HRESET        = 1'b0;
        bus.irq_ack_i = 1'b0;
        bus.pending_i = 32'h0000_0002;
        tick();
        check("rr_after_req", {31'd0, bus.irq_req_o}, 32'd1);
        check("rr_after_id",  {27'd0, bus.irq_id_o},  32'd1);
        // Reset during CLEAR drops the pulse at the next edge.
        bus.irq_ack_i = 1'b1;
        tick();
        check("rc_clear", bus.clear_o, 32'h0000_0002);
        bus.irq_ack_i = 1'b0;
        HRESET        = 1'b1;
        tick();
        check("rc_clear0", bus.clear_o,            32'd0);
        check("rc_req0",   {31'd0, bus.irq_req_o}, 32'd0);
        HRESET = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
